// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencing logic.
package md_pkg;

  // Encoding of the E-stage mult/div/move request (req_op).
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } md_op_e;

  // Default launch-to-commit latencies of the calculator.
  localparam int MULT_LAT_D = 5;
  localparam int DIV_LAT_D  = 10;

  // Scheduler states: IDLE accepts requests, RUN counts an operation down.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/md_if.sv
// Request/response bundle between the pipeline and the md scheduler.
interface md_if #(
  parameter int CNT_W = 4
);
  logic             req_valid;
  logic [2:0]       req_op;
  logic             d_uses_md;
  logic             cancel;
  logic             launch;
  logic [1:0]       calc_ctrl;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;
  logic             rd_lo;
  logic             stall;
  logic             busy;
  logic [CNT_W-1:0] count;

  // Pipeline side: presents requests, consumes control outputs.
  modport master (
    output req_valid, req_op, d_uses_md, cancel,
    input  launch, calc_ctrl, commit, wr_hi, wr_lo, rd_lo, stall, busy, count
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_op, d_uses_md, cancel,
    output launch, calc_ctrl, commit, wr_hi, wr_lo, rd_lo, stall, busy, count
  );
endinterface

// File: rtl/md_op_decode.sv
// Pure decode of req_op into the classes the scheduler acts on.
module md_op_decode
  import md_pkg::*;
(
  input  logic [2:0] req_op,
  output logic       is_calc,
  output logic       is_div,
  output logic       is_unsigned,
  output logic       is_mfrom,
  output logic       is_mto,
  output logic       target_lo
);

  // Classify the opcode; target_lo selects LO for moves and the signed/unsigned bit for calcs.
  always_comb begin
    is_calc     = 1'b0;
    is_div      = 1'b0;
    is_unsigned = 1'b0;
    is_mfrom    = 1'b0;
    is_mto      = 1'b0;
    target_lo   = req_op[0];
    unique case (md_op_e'(req_op))
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        is_calc     = 1'b1;
        is_div      = req_op[1];
        is_unsigned = req_op[0];
      end
      OP_MFHI, OP_MFLO: is_mfrom = 1'b1;
      OP_MTHI, OP_MTLO: is_mto   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Launch/commit sequencer and D-stage stall for the HI/LO multiply/divide unit.
module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D,
  parameter int CNT_W    = 4
) (
  input  logic  clk,
  input  logic  reset,
  md_if.slave   bus
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q;
  logic             is_calc, is_div, is_unsigned, is_mfrom, is_mto, target_lo;
  logic             launch, commit, wr_hi, wr_lo, first;
  logic [1:0]       calc_ctrl;

  md_op_decode u_decode (
    .req_op      (bus.req_op),
    .is_calc     (is_calc),
    .is_div      (is_div),
    .is_unsigned (is_unsigned),
    .is_mfrom    (is_mfrom),
    .is_mto      (is_mto),
    .target_lo   (target_lo)
  );

  // Next state, counter and one-cycle strobes; requests are only honoured in IDLE.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a value held, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    launch    = 1'b0;
    calc_ctrl = 2'b00;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    first     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && !reset) begin
          if (is_calc) begin
            launch    = 1'b1;
            calc_ctrl = {is_div, is_unsigned};
            state_d   = RUN;
            cnt_d     = is_div ? DIV_CNT : MULT_CNT;
          end
          if (is_mto) begin
            wr_hi = !target_lo;
            wr_lo = target_lo;
          end
        end
      end
      RUN: begin
        // A flush can only hit the operation in its first RUN cycle; it beats a latency-1 commit.
        first = (cnt_q == (div_q ? DIV_CNT : MULT_CNT));
        if (first && bus.cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          commit  = !reset;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, counter and operation kind registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (launch) div_q <= is_div;
    end
  end

  assign bus.launch    = launch;
  assign bus.calc_ctrl = calc_ctrl;
  assign bus.commit    = commit;
  assign bus.wr_hi     = wr_hi;
  assign bus.wr_lo     = wr_lo;
  assign bus.rd_lo     = is_mfrom & target_lo;
  assign bus.busy      = (state_q == RUN);
  assign bus.count     = cnt_q;
  assign bus.stall     = bus.d_uses_md & (bus.busy | launch);

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench: two schedulers (default and short latencies) against a timestamp model.
module tb_md_scheduler;
  import md_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_op;
  logic       d_uses_md;
  logic       cancel;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  always #5 clk = ~clk;

  md_if #(.CNT_W(4)) bus0 ();
  md_if #(.CNT_W(4)) bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_op    = req_op;
  assign bus0.d_uses_md = d_uses_md;
  assign bus0.cancel    = cancel;
  assign bus1.req_valid = req_valid;
  assign bus1.req_op    = req_op;
  assign bus1.d_uses_md = d_uses_md;
  assign bus1.cancel    = cancel;

  md_scheduler #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  md_scheduler #(.MULT_LAT(1), .DIV_LAT(3), .CNT_W(4)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // ---------------- behavioural model ----------------
  // An operation is described by its launch cycle and latency; everything else
  // follows from the elapsed cycle count k = cyc - start (k = 1..lat while running).
  typedef struct {
    bit launch, commit, wr_hi, wr_lo, rd_lo, stall, busy;
    int ctrl;
    int count;
  } obs_t;

  int ml [2] = '{5, 1};
  int dl [2] = '{10, 3};
  bit m_run [2] = '{0, 0};
  int m_start [2] = '{0, 0};
  int m_lat [2] = '{0, 0};

  function automatic obs_t model_out(int i);
    obs_t e;
    int k;
    bit idle_req;
    k        = cyc - m_start[i];
    e.busy   = m_run[i];
    e.count  = m_run[i] ? (m_lat[i] - k + 1) : 0;
    e.commit = !reset && m_run[i] && (k == m_lat[i]) && !(k == 1 && cancel);
    idle_req = !reset && !m_run[i] && req_valid;
    e.launch = idle_req && (req_op < 3'd4);
    e.ctrl   = int'(req_op[1:0]);
    e.wr_hi  = idle_req && (req_op == 3'd6);
    e.wr_lo  = idle_req && (req_op == 3'd7);
    e.rd_lo  = (req_op == 3'd5);
    e.stall  = d_uses_md && (e.busy || e.launch);
    return e;
  endfunction

  function automatic obs_t dut_out(int i);
    obs_t a;
    if (i == 0) begin
      a.launch = bus0.launch; a.commit = bus0.commit; a.wr_hi = bus0.wr_hi;
      a.wr_lo  = bus0.wr_lo;  a.rd_lo  = bus0.rd_lo;  a.stall = bus0.stall;
      a.busy   = bus0.busy;   a.ctrl   = int'(bus0.calc_ctrl); a.count = int'(bus0.count);
    end else begin
      a.launch = bus1.launch; a.commit = bus1.commit; a.wr_hi = bus1.wr_hi;
      a.wr_lo  = bus1.wr_lo;  a.rd_lo  = bus1.rd_lo;  a.stall = bus1.stall;
      a.busy   = bus1.busy;   a.ctrl   = int'(bus1.calc_ctrl); a.count = int'(bus1.count);
    end
    return a;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Advance the model at each edge using the inputs that were stable during the cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      obs_t e;
      int k;
      e = model_out(i);
      k = cyc - m_start[i];
      if (reset) begin
        m_run[i] = 1'b0;
      end else if (m_run[i]) begin
        if ((k == 1 && cancel) || k == m_lat[i]) m_run[i] = 1'b0;
      end else if (e.launch) begin
        m_run[i]   = 1'b1;
        m_start[i] = cyc;
        m_lat[i]   = req_op[1] ? dl[i] : ml[i];
      end
    end
    cyc++;
  end

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        obs_t e, a;
        string p;
        e = model_out(i);
        a = dut_out(i);
        p = $sformatf("dut%0d.", i);
        check({p, "launch"}, int'(a.launch), int'(e.launch));
        check({p, "commit"}, int'(a.commit), int'(e.commit));
        check({p, "wr_hi"},  int'(a.wr_hi),  int'(e.wr_hi));
        check({p, "wr_lo"},  int'(a.wr_lo),  int'(e.wr_lo));
        check({p, "rd_lo"},  int'(a.rd_lo),  int'(e.rd_lo));
        check({p, "stall"},  int'(a.stall),  int'(e.stall));
        check({p, "busy"},   int'(a.busy),   int'(e.busy));
        check({p, "count"},  a.count,        e.count);
        if (e.launch) check({p, "calc_ctrl"}, a.ctrl, e.ctrl);
      end
    end
  end

  // Drive one cycle of inputs just after the edge, return mid-cycle for checks.
  task automatic tick(input bit r, input bit v, input logic [2:0] op, input bit du, input bit c);
    @(posedge clk);
    #1;
    reset     = r;
    req_valid = v;
    req_op    = op;
    d_uses_md = du;
    cancel    = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit du);
    for (int j = 0; j < n; j++) tick(0, 0, 3'd0, du, 0);
  endtask

  // ---------------- stimulus with literal expectations ----------------
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; d_uses_md = 1'b0; cancel = 1'b0;
    tick(1, 0, 3'd0, 0, 0);
    tick(1, 0, 3'd0, 0, 0);
    tick(0, 0, 3'd0, 0, 0);
    check("reset busy",  int'(bus0.busy),   0);
    check("reset count", int'(bus0.count),  0);
    check("reset commit", int'(bus0.commit), 0);

    // mult with a dependent md instruction in D throughout
    tick(0, 1, OP_MULT, 1, 0);
    check("mult launch", int'(bus0.launch), 1);
    check("mult launch stall", int'(bus0.stall), 1);
    check("mult calc_ctrl", int'(bus0.calc_ctrl), 0);
    for (int k = 5; k >= 1; k--) begin
      tick(0, 0, 3'd0, 1, 0);
      check($sformatf("mult count %0d", k), int'(bus0.count), k);
      check($sformatf("mult commit at count %0d", k), int'(bus0.commit), (k == 1) ? 1 : 0);
      check($sformatf("mult stall at count %0d", k), int'(bus0.stall), 1);
    end
    tick(0, 0, 3'd0, 1, 0);
    check("mult done busy", int'(bus0.busy), 0);
    check("mult done stall", int'(bus0.stall), 0);

    // divu then back-to-back mult
    tick(0, 1, OP_DIVU, 0, 0);
    check("divu calc_ctrl", int'(bus0.calc_ctrl), 3);
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 3'd0, 0, 0);
      check($sformatf("divu commit T+%0d", k), int'(bus0.commit), (k == 10) ? 1 : 0);
    end
    tick(0, 1, OP_MULT, 0, 0);
    check("b2b mult launch", int'(bus0.launch), 1);
    tick(0, 0, 3'd0, 0, 0);
    check("b2b mult count", int'(bus0.count), 5);
    idle(5, 0);

    // div cancelled in its first RUN cycle
    tick(0, 1, OP_DIV, 0, 0);
    tick(0, 0, 3'd0, 0, 1);
    check("div cancel commit", int'(bus0.commit), 0);
    check("div cancel count", int'(bus0.count), 10);
    tick(0, 0, 3'd0, 0, 0);
    check("div cancelled busy", int'(bus0.busy), 0);
    check("div cancelled count", int'(bus0.count), 0);
    idle(1, 0);

    // late cancel is ignored
    tick(0, 1, OP_DIV, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 3'd0, 0, (k == 3));
      check($sformatf("late cancel commit T+%0d", k), int'(bus0.commit), (k == 10) ? 1 : 0);
    end
    idle(1, 0);

    // moves
    tick(0, 1, OP_MTHI, 1, 0);
    check("mthi wr_hi", int'(bus0.wr_hi), 1);
    check("mthi stall", int'(bus0.stall), 0);
    tick(0, 1, OP_MULT, 0, 0);
    tick(0, 1, OP_MTLO, 1, 0);
    check("mtlo in RUN wr_lo", int'(bus0.wr_lo), 0);
    check("mtlo in RUN count", int'(bus0.count), 5);
    tick(0, 0, 3'd0, 0, 0);
    check("mtlo in RUN count next", int'(bus0.count), 4);
    idle(4, 0);

    // reset at count 3 of a div
    tick(0, 1, OP_DIV, 1, 0);
    idle(7, 1);
    tick(1, 0, 3'd0, 1, 0);
    check("reset cycle count", int'(bus0.count), 3);
    check("reset cycle commit", int'(bus0.commit), 0);
    tick(0, 0, 3'd0, 1, 0);
    check("after reset count", int'(bus0.count), 0);
    check("after reset busy", int'(bus0.busy), 0);
    check("after reset stall", int'(bus0.stall), 0);
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 3'd0, 1, 0);
      check("no commit after reset", int'(bus0.commit), 0);
    end

    // latency-1 multiply on the second instance
    tick(0, 1, OP_MULT, 0, 0);
    check("lat1 launch", int'(bus1.launch), 1);
    tick(0, 0, 3'd0, 0, 0);
    check("lat1 commit", int'(bus1.commit), 1);
    check("lat1 count", int'(bus1.count), 1);
    tick(0, 0, 3'd0, 0, 0);
    check("lat1 idle", int'(bus1.busy), 0);
    idle(4, 0);
    tick(0, 1, OP_MULT, 0, 0);
    tick(0, 0, 3'd0, 0, 1);
    check("lat1 cancel commit", int'(bus1.commit), 0);
    tick(0, 0, 3'd0, 0, 0);
    check("lat1 cancel idle", int'(bus1.busy), 0);
    idle(5, 0);

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      tick(($urandom_range(99) == 0), $urandom_range(1) == 1, 3'($urandom_range(7)),
           $urandom_range(1) == 1, ($urandom_range(4) == 0));
    end
    idle(12, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Sequencing controller for the HI/LO multiply/divide unit in the five-stage MIPS pipeline. Accepts the E-stage mult/div/move request and issues a one-cycle launch. It counts the operation latency, produces the D-stage stall for dependent HI/LO instructions, and gates the final HI/LO write with a commit pulse so that a flush can cancel a just-launched operation.

## Interface
Parameters:
- MULT_LAT, 5, cycles from launch to commit for mult/multu
- DIV_LAT, 10, cycles from launch to commit for div/divu
- CNT_W, 4, counter width; must hold DIV_LAT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  E-stage instruction is a valid md instruction
- req_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo
- d_uses_md  in  1  D-stage instruction is any md instruction
- cancel  in  1  flush of the instruction that was in E last cycle
- launch  out  1  start calculator this cycle
- calc_ctrl  out  2  {divide, unsigned}, valid while launch=1
- commit  out  1  write calculator result into HI and LO this cycle
- wr_hi, wr_lo  out  1  move write (mthi/mtlo) into HI/LO this cycle
- rd_lo  out  1  mfhi/mflo read select, 1 = LO
- stall  out  1  hold D stage
- busy  out  1  operation in flight (state RUN)
- count  out  CNT_W  remaining cycles, 0 when idle

## Operation
- States: IDLE, RUN. Reset gives state IDLE, count 0, and all outputs 0.
- In IDLE with req_valid and req_op<4, launch=1 combinationally. calc_ctrl = {req_op[1], req_op[0]}.
  - At the next edge the state becomes RUN and count is loaded with DIV_LAT if req_op[1], else MULT_LAT.
- In IDLE with req_valid and req_op 6 or 7, wr_hi or wr_lo is 1 combinationally. The state does not change.
- rd_lo = req_op[0] when req_op is 4 or 5, otherwise 0. This is purely combinational.
- In RUN, count decrements by 1 each edge.
  - commit=1 in the cycle where count==1, unless that cycle is cancelled.
  - At the following edge the state returns to IDLE with count 0.
- cancel is honoured only in the first RUN cycle (count==loaded latency). The state goes to IDLE and count to 0 at the next edge, with no commit. cancel at any other time is ignored.
- cancel in the launch cycle itself is ignored. It refers to the older instruction.
- req_valid with any op during RUN is a protocol violation and is ignored: no launch, no move write, state unchanged. rd_lo is still driven.
- stall = d_uses_md & (busy | launch).
- A latency parameter of 1 is legal: commit happens in the first RUN cycle. If that cycle is cancelled, cancel wins and there is no commit.

## Timing
- A mult launched in cycle T:
  - RUN from T+1, count 5,4,3,2,1 over T+1..T+5
  - commit in T+5, IDLE in T+6
  - stall for md in D over T..T+5
- A div launched in cycle T: commit in T+10, IDLE in T+11.
- Back-to-back: a new launch is possible in the first IDLE cycle (T+6 for mult).
- A move write takes 0 extra cycles and is not stalled unless RUN.
- reset mid-RUN returns to IDLE at that edge. No commit is issued in the reset cycle or after it.

## Structure
- Shared package md_pkg holds:
  - the op encodings (OP_MULT..OP_MTLO)
  - default latencies MULT_LAT_D=5 and DIV_LAT_D=10
  - the state enum {IDLE, RUN}
- One combinational sub-module, md_op_decode. It maps req_op to is_calc, is_div, is_unsigned, is_mfrom, is_mto, and target_lo.
- The FSM, counter and stall logic live in md_scheduler.

## Test plan
- mult launched at T=10 with d_uses_md=1 throughout -> launch in 10; count 5..1 in 11..15; commit only in 15; stall in 10..15; busy 0 in 16.
- divu launched with no cancel -> calc_ctrl=2'b11 in the launch cycle; commit exactly 10 cycles later; then a mult launched in the first idle cycle -> launch=1 and count=5 next.
- div launched at T and cancel=1 in T+1 -> IDLE and count 0 at T+2; commit never asserted. Also: cancel=1 in T+3 -> ignored, commit still in T+10.
- mthi in IDLE -> wr_hi=1 and stall=0 in the same cycle. mtlo issued during RUN -> wr_lo stays 0 and count keeps decrementing.
- reset asserted at count 3 of a div -> count 0, busy 0, stall 0 next cycle; no commit afterwards.
- MULT_LAT=1: launch at T -> commit at T+1, IDLE at T+2. The same launch with cancel at T+1 -> no commit.
